// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: 64-word data RAM plus CYCLE/LED/timer MMIO for a word-addressed CPU MEM stage.
// Reads are combinational, writes commit on clk, with no backpressure. The timer is built only when `DMEM_MMIO_TIMER_EN is defined.
module dmem_mmio_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [15:0] leds,
  output logic        irq,
  output logic        bus_err
);

  localparam logic [23:0] MmioPage = 24'hFFFFFF;
  localparam logic [5:0]  IdxCycle = 6'd0;
  localparam logic [5:0]  IdxLed   = 6'd1;

  logic [31:0] ram [64];
  logic [31:0] cycleCnt;
  logic [15:0] ledReg;
  logic [5:0]  wordIdx;
  logic        isRam, isMmio;
  logic        selCycle, selLed, selTcmp, selTctrl, selTcnt;
  logic        mapped;
  logic [31:0] timerRdata;
  logic        unusedAddrLsbs;

  assign wordIdx        = addr[7:2];
  assign unusedAddrLsbs = ^addr[1:0];
  assign isRam          = (addr[31:8] == 24'h0);
  assign isMmio         = (addr[31:8] == MmioPage);
  assign selCycle       = isMmio && (wordIdx == IdxCycle);
  assign selLed         = isMmio && (wordIdx == IdxLed);
  assign mapped         = isRam | selCycle | selLed | selTcmp | selTctrl | selTcnt;

`ifdef DMEM_MMIO_TIMER_EN
  localparam logic [5:0] IdxTcmp  = 6'd2;
  localparam logic [5:0] IdxTctrl = 6'd3;
  localparam logic [5:0] IdxTcnt  = 6'd4;

  logic [31:0] tcmp, tcnt;
  logic        tEn, tStat, tAuto;
  logic        tMatch, tHit;
  logic        wrTcmp, wrTctrl, wrTcnt;

  assign selTcmp  = isMmio && (wordIdx == IdxTcmp);
  assign selTctrl = isMmio && (wordIdx == IdxTctrl);
  assign selTcnt  = isMmio && (wordIdx == IdxTcnt);
  assign wrTcmp   = memwrite && selTcmp;
  assign wrTctrl  = memwrite && selTctrl;
  assign wrTcnt   = memwrite && selTcnt;
  assign tMatch   = (tcnt == tcmp);
  assign tHit     = tEn && tMatch;
  assign irq      = tStat;

  always_comb begin
    timerRdata = '0;
    if (selTcmp)       timerRdata = tcmp;
    else if (selTctrl) timerRdata = {29'h0, tAuto, tStat, tEn};
    else if (selTcnt)  timerRdata = tcnt;
  end

  // Software writes win over the timer's own update; a match always leaves STAT set.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcmp  <= '0;
      tcnt  <= '0;
      tEn   <= 1'b0;
      tStat <= 1'b0;
      tAuto <= 1'b0;
    end else begin
      if (wrTcmp) tcmp <= writedata;

      if (wrTcnt)    tcnt <= writedata;
      else if (tHit) tcnt <= tAuto ? 32'h0 : tcnt;
      else if (tEn)  tcnt <= tcnt + 32'd1;

      if (wrTctrl) begin
        tEn   <= writedata[0];
        tAuto <= writedata[2];
      end else if (tHit && !tAuto) begin
        tEn <= 1'b0;
      end

      if (tHit)                         tStat <= 1'b1;
      else if (wrTctrl && writedata[1]) tStat <= 1'b0;
    end
  end
`else
  assign selTcmp    = 1'b0;
  assign selTctrl   = 1'b0;
  assign selTcnt    = 1'b0;
  assign timerRdata = '0;
  assign irq        = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    if (isRam)         readdata = ram[wordIdx];
    else if (selCycle) readdata = cycleCnt;
    else if (selLed)   readdata = {16'h0, ledReg};
    else               readdata = timerRdata;
  end

  // RAM is deliberately left out of reset so data survives a CPU reset.
  always_ff @(posedge clk) begin
    if (memwrite && isRam) ram[wordIdx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycleCnt <= '0;
      ledReg   <= '0;
      bus_err  <= 1'b0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (memwrite && selLed) ledReg <= writedata[15:0];
      bus_err <= !mapped;
    end
  end

  assign leds = ledReg;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Randomized and directed bench for dmem_mmio_responder against a memory-map reference model.
module tb_dmem_mmio_responder;

  logic        clk = 1'b0;
  logic        reset, memwrite;
  logic [31:0] addr, writedata, readdata;
  logic [15:0] leds;
  logic        irq, bus_err;

  int nTests = 0;
  int nFail  = 0;

  logic [31:0] ramM [64];
  bit          ramKnown [64];
  logic [31:0] cycM = 32'h0;
  logic [15:0] ledM = 16'h0;

  localparam logic [31:0] A_CYCLE = 32'hFFFF_FF00;
  localparam logic [31:0] A_LED   = 32'hFFFF_FF04;
  localparam logic [31:0] A_TCMP  = 32'hFFFF_FF08;
  localparam logic [31:0] A_TCTRL = 32'hFFFF_FF0C;
  localparam logic [31:0] A_TCNT  = 32'hFFFF_FF10;
`ifdef DMEM_MMIO_TIMER_EN
  localparam int HOLE_LO = 5;
`else
  localparam int HOLE_LO = 2;
`endif

  dmem_mmio_responder dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .writedata(writedata),
    .readdata(readdata), .leds(leds), .irq(irq), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    if (reset) cycM = 32'h0;
    else       cycM = cycM + 32'd1;
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; addr = a; writedata = d;
    tick();
    memwrite = 1'b0; addr = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a);
    memwrite = 1'b0; addr = a;
    #1;
  endtask

  function automatic logic [31:0] expRead(input logic [31:0] a);
    if (a[31:8] == 24'h0)   return ramM[a[7:2]];
    if ((a & ~32'h3) == A_CYCLE) return cycM;
    if ((a & ~32'h3) == A_LED)   return {16'h0, ledM};
    return 32'h0;
  endfunction

  function automatic bit expMapped(input logic [31:0] a);
    if (a[31:8] == 24'h0) return 1'b1;
    if (a[31:8] == 24'hFFFFFF && int'(a[7:2]) < HOLE_LO) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    reset = 1'b1; memwrite = 1'b0; addr = 32'h0; writedata = 32'h0;
    repeat (3) tick();
    nTests++; if (leds !== 16'h0) begin nFail++; $display("FAIL reset_leds: got %h expected 0000", leds); end
    nTests++; if (irq !== 1'b0) begin nFail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    nTests++; if (bus_err !== 1'b0) begin nFail++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
    rd(A_CYCLE);
    nTests++; if (readdata !== 32'h0) begin nFail++; $display("FAIL reset_cycle: got %h expected 0", readdata); end
    reset = 1'b0; ledM = 16'h0;
  endtask

  task automatic test_ram_basic();
    wr(32'h10, 32'h1234_5678);
    ramM[4] = 32'h1234_5678; ramKnown[4] = 1'b1;
    rd(32'h10);
    nTests++; if (readdata !== 32'h1234_5678) begin nFail++; $display("FAIL ram_read: got %h expected 12345678", readdata); end
    nTests++; if (bus_err !== 1'b0) begin nFail++; $display("FAIL ram_no_err: got %b expected 0", bus_err); end
    rd(32'h110);
    nTests++; if (readdata !== 32'h0) begin nFail++; $display("FAIL unmapped_read: got %h expected 0", readdata); end
    tick();
    nTests++; if (bus_err !== 1'b1) begin nFail++; $display("FAIL unmapped_err: got %b expected 1", bus_err); end
    rd(32'h10);
    tick();
    nTests++; if (bus_err !== 1'b0) begin nFail++; $display("FAIL err_one_cycle: got %b expected 0", bus_err); end
  endtask

  task automatic test_cycle();
    reset = 1'b1; tick(); reset = 1'b0; ledM = 16'h0;
    repeat (10) tick();
    rd(A_CYCLE);
    nTests++; if (readdata !== 32'd10) begin nFail++; $display("FAIL cycle_count: got %0d expected 10", readdata); end
    force dut.cycleCnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycleCnt;
    cycM = 32'hFFFF_FFFF;
    #1;
    nTests++; if (readdata !== 32'hFFFF_FFFF) begin nFail++; $display("FAIL cycle_preload: got %h expected ffffffff", readdata); end
    tick();
    nTests++; if (readdata !== 32'h0) begin nFail++; $display("FAIL cycle_wrap: got %h expected 0", readdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, d, exp;
      bit we, known, mp;
      int kind;
      kind = $urandom_range(0, 4);
      we   = 1'($urandom_range(0, 1));
      d    = $urandom;
      case (kind)
        0: a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        1: a = A_LED | 32'($urandom_range(0, 3));
        2: a = A_CYCLE | 32'($urandom_range(0, 3));
        3: begin
          a = $urandom;
          if (a[31:8] == 24'h0 || a[31:8] == 24'hFFFFFF) a = a ^ 32'h0010_0000;
        end
        default: a = {24'hFFFFFF, 6'($urandom_range(HOLE_LO, 63)), 2'($urandom_range(0, 3))};
      endcase
      known = (a[31:8] != 24'h0) || ramKnown[a[7:2]];
      exp   = expRead(a);
      mp    = expMapped(a);
      memwrite = we; addr = a; writedata = d;
      #1;
      if (known) begin
        nTests++;
        if (readdata !== exp) begin nFail++; $display("FAIL rand_read[%0d] addr %h: got %h expected %h", i, a, readdata, exp); end
      end
      tick();
      if (we && a[31:8] == 24'h0) begin ramM[a[7:2]] = d; ramKnown[a[7:2]] = 1'b1; end
      if (we && (a & ~32'h3) == A_LED) ledM = d[15:0];
      nTests++;
      if (bus_err !== !mp) begin nFail++; $display("FAIL rand_bus_err[%0d] addr %h: got %b expected %b", i, a, bus_err, !mp); end
      nTests++;
      if (leds !== ledM) begin nFail++; $display("FAIL rand_leds[%0d]: got %h expected %h", i, leds, ledM); end
    end
    memwrite = 1'b0; addr = 32'h0;
  endtask

  task automatic test_led();
    wr(32'h10, 32'h1234_5678);
    wr(A_LED, 32'hFFFF_ABCD);
    nTests++; if (leds !== 16'hABCD) begin nFail++; $display("FAIL led_out: got %h expected abcd", leds); end
    rd(A_LED);
    nTests++; if (readdata !== 32'h0000_ABCD) begin nFail++; $display("FAIL led_read: got %h expected 0000abcd", readdata); end
    reset = 1'b1; tick(); reset = 1'b0; ledM = 16'h0;
    nTests++; if (leds !== 16'h0) begin nFail++; $display("FAIL led_reset: got %h expected 0000", leds); end
    rd(32'h10);
    nTests++; if (readdata !== 32'h1234_5678) begin nFail++; $display("FAIL ram_survives_reset: got %h expected 12345678", readdata); end
  endtask

`ifdef DMEM_MMIO_TIMER_EN
  task automatic test_timer_auto();
    int c;
    c = $urandom_range(2, 9);
    wr(A_TCMP, 32'(c)); wr(A_TCNT, 32'h0); wr(A_TCTRL, 32'h5);
    rd(A_TCNT);
    for (int k = 1; k <= 3 * (c + 1); k++) begin
      tick();
      nTests++;
      if (readdata !== 32'(k % (c + 1))) begin nFail++; $display("FAIL auto_tcnt k=%0d: got %0d expected %0d", k, readdata, k % (c + 1)); end
      nTests++;
      if (irq !== (k >= c + 1)) begin nFail++; $display("FAIL auto_irq k=%0d: got %b expected %b", k, irq, k >= c + 1); end
    end
    wr(A_TCTRL, 32'h7);
    nTests++; if (irq !== 1'b0) begin nFail++; $display("FAIL auto_w1c: got %b expected 0", irq); end
    rd(A_TCTRL);
    nTests++; if (readdata !== 32'h5) begin nFail++; $display("FAIL auto_tctrl: got %h expected 5", readdata); end
    rd(A_TCNT);
    nTests++; if (readdata !== 32'h1) begin nFail++; $display("FAIL auto_after_w1c: got %0d expected 1", readdata); end
    wr(A_TCTRL, 32'h0);
    rd(A_TCNT);
    repeat (3) tick();
    nTests++; if (readdata !== 32'h2) begin nFail++; $display("FAIL en0_hold: got %0d expected 2", readdata); end
  endtask

  task automatic test_timer_oneshot();
    int c;
    c = $urandom_range(2, 7);
    wr(A_TCMP, 32'(c)); wr(A_TCNT, 32'h0); wr(A_TCTRL, 32'h1);
    rd(A_TCNT);
    for (int k = 1; k <= c + 4; k++) begin
      tick();
      nTests++;
      if (readdata !== 32'((k < c) ? k : c)) begin nFail++; $display("FAIL oneshot_tcnt k=%0d: got %0d expected %0d", k, readdata, (k < c) ? k : c); end
      nTests++;
      if (irq !== (k >= c + 1)) begin nFail++; $display("FAIL oneshot_irq k=%0d: got %b expected %b", k, irq, k >= c + 1); end
    end
    rd(A_TCTRL);
    nTests++; if (readdata !== 32'h2) begin nFail++; $display("FAIL oneshot_en_cleared: got %h expected 2", readdata); end
    wr(A_TCTRL, 32'h2);
    nTests++; if (irq !== 1'b0) begin nFail++; $display("FAIL oneshot_w1c: got %b expected 0", irq); end
    wr(A_TCNT, 32'h0); wr(A_TCTRL, 32'h1);
    repeat (c) tick();
    wr(A_TCTRL, 32'h3);
    nTests++; if (irq !== 1'b1) begin nFail++; $display("FAIL w1c_in_match: got %b expected 1", irq); end
    rd(A_TCTRL);
    nTests++; if (readdata !== 32'h3) begin nFail++; $display("FAIL en_write_in_match: got %h expected 3", readdata); end
    wr(A_TCTRL, 32'h2);
  endtask

  task automatic test_timer_priority();
    wr(A_TCMP, 32'd50); wr(A_TCNT, 32'h0); wr(A_TCTRL, 32'h5);
    tick(); tick();
    wr(A_TCNT, 32'h20);
    rd(A_TCNT);
    nTests++; if (readdata !== 32'h20) begin nFail++; $display("FAIL tcnt_write_over_inc: got %h expected 20", readdata); end
    wr(A_TCNT, 32'd50);
    wr(A_TCNT, 32'd7);
    nTests++; if (irq !== 1'b1) begin nFail++; $display("FAIL match_with_write_irq: got %b expected 1", irq); end
    rd(A_TCNT);
    nTests++; if (readdata !== 32'd7) begin nFail++; $display("FAIL tcnt_write_over_reload: got %0d expected 7", readdata); end
    wr(A_TCTRL, 32'h2);
  endtask

  task automatic test_timer_reset_abort();
    wr(A_TCMP, 32'd10); wr(A_TCNT, 32'h0); wr(A_TCTRL, 32'h5);
    repeat (4) tick();
    reset = 1'b1; tick(); reset = 1'b0; ledM = 16'h0;
    repeat (12) tick();
    nTests++; if (irq !== 1'b0) begin nFail++; $display("FAIL reset_abort_irq: got %b expected 0", irq); end
    rd(A_TCTRL);
    nTests++; if (readdata !== 32'h0) begin nFail++; $display("FAIL reset_abort_tctrl: got %h expected 0", readdata); end
    rd(A_TCNT);
    nTests++; if (readdata !== 32'h0) begin nFail++; $display("FAIL reset_abort_tcnt: got %h expected 0", readdata); end
  endtask
`else
  task automatic test_timer_disabled();
    memwrite = 1'b1; addr = A_TCTRL; writedata = 32'h7;
    #1;
    nTests++; if (readdata !== 32'h0) begin nFail++; $display("FAIL notimer_read: got %h expected 0", readdata); end
    tick();
    memwrite = 1'b0; addr = 32'h0;
    nTests++; if (bus_err !== 1'b1) begin nFail++; $display("FAIL notimer_err: got %b expected 1", bus_err); end
    nTests++; if (irq !== 1'b0) begin nFail++; $display("FAIL notimer_irq: got %b expected 0", irq); end
    tick();
    nTests++; if (bus_err !== 1'b0) begin nFail++; $display("FAIL notimer_err_pulse: got %b expected 0", bus_err); end
    rd(A_TCTRL);
    nTests++; if (readdata !== 32'h0) begin nFail++; $display("FAIL notimer_readback: got %h expected 0", readdata); end
    rd(32'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_ram_basic();
    test_cycle();
    test_random();
    test_led();
`ifdef DMEM_MMIO_TIMER_EN
    test_timer_auto();
    test_timer_oneshot();
    test_timer_priority();
    test_timer_reset_abort();
`else
    test_timer_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

Interface
REQ-001 SHALL have ports clk (in, 1, clock) and reset (in, 1, synchronous active-high reset), listed first; one clock, no other clock domains.
REQ-002 SHALL have input memwrite (1): store request from the CPU MEM stage.
REQ-003 SHALL have input addr (32): byte address from the CPU MEM stage; addr[1:0] ignored, word accesses only.
REQ-004 SHALL have input writedata (32): store data.
REQ-005 SHALL have output readdata (32): load data, combinational from addr, valid in the same cycle.
REQ-006 SHALL have output leds (16): contents of the LED register.
REQ-007 SHALL have output irq (1): timer status flag.
REQ-008 SHALL have output bus_err (1): registered one-cycle pulse on any access to an unmapped address.

Function
REQ-009 Address map:
- 0x0000_0000-0x0000_00FC: 64-word RAM, indexed by addr[7:2].
- 0xFFFF_FF00: CYCLE (RO).
- 0xFFFF_FF04: LED (RW, bits 15:0; upper bits read 0).
- 0xFFFF_FF08: TCMP (RW).
- 0xFFFF_FF0C: TCTRL (bit0 EN, bit1 STAT, bit2 AUTO).
- 0xFFFF_FF10: TCNT (RW).
REQ-010 Writes SHALL commit on the rising clk edge when memwrite=1; reads SHALL have zero latency and need no handshake.
REQ-011 Unmapped reads SHALL return 0x0000_0000; unmapped writes SHALL be ignored; either SHALL raise bus_err in the next cycle for exactly one cycle per accessing cycle.
REQ-012 Writes to CYCLE SHALL be ignored without bus_err.
REQ-013 CYCLE SHALL increment by 1 every cycle and wrap 0xFFFF_FFFF -> 0.
REQ-014 Timer, per cycle with EN=1:
- TCNT != TCMP: TCNT += 1, wrapping at 2^32.
- TCNT == TCMP: STAT <= 1; if AUTO=1, TCNT <= 0 and EN stays 1; if AUTO=0, EN <= 0 and TCNT holds (one-shot).
REQ-015 With EN=0, TCNT SHALL hold its value.
REQ-016 A write to TCNT SHALL take priority over the increment/reload in that cycle.
REQ-017 Writing TCTRL SHALL load EN and AUTO from writedata; STAT is write-1-to-clear.
REQ-018 If a STAT set event and a W1C of STAT occur in the same cycle, STAT SHALL end at 1.
REQ-019 A TCTRL write that sets EN=1 in the same cycle as a match SHALL leave EN=1.
REQ-020 irq SHALL equal STAT (level, not pulse).
REQ-021 Read of RAM during a same-cycle write to the same word SHALL return the old data.

Reset
REQ-022 On reset=1 at a clk edge, SHALL clear CYCLE, LED, TCMP, TCNT, TCTRL and bus_err to 0; leds=0, irq=0.
REQ-023 RAM contents SHALL NOT be cleared by reset.
REQ-024 Reset SHALL take priority over any same-cycle write or timer event.
REQ-025 Reset asserted mid-count SHALL abort the timer with no STAT set.

Configuration
REQ-026 Macro DMEM_MMIO_TIMER_EN SHALL control the timer.
- Defined: TCMP/TCTRL/TCNT and irq behave per REQ-014 to REQ-020.
- Undefined: the timer registers are not built; 0xFFFF_FF08-0xFFFF_FF10 are unmapped per REQ-011; irq is tied to 0.

Verification
REQ-027 Reset; store 0x1234_5678 to 0x0000_0010; load 0x10 -> readdata=0x1234_5678; load 0x0000_0110 -> readdata=0, bus_err=1 next cycle only.
REQ-028 Release reset; read CYCLE after 10 cycles -> 10; preload via force to 0xFFFF_FFFF -> next cycle 0.
REQ-029 TCMP=5, TCNT=0, TCTRL=0b101 -> STAT/irq rise 6 cycles after the write; TCNT=0 the same cycle; repeats every 6 cycles; W1C 0x2 clears irq.
REQ-030 TCMP=3, TCTRL=0b001 -> irq=1 and EN=0 after the match; TCNT holds 3; W1C in the exact match cycle -> irq stays 1.
REQ-031 Store 0xFFFF_ABCD to LED -> leds=0xABCD, LED readback=0x0000_ABCD; reset -> leds=0, RAM word 0x10 still 0x1234_5678.
REQ-032 Build without DMEM_MMIO_TIMER_EN: store to 0xFFFF_FF0C -> bus_err pulse, irq=0, readback 0.
